i2s_slave_rx: RTL and testbench



---
 rtl/i2s_slave_rx.sv | 189 ++++++++++++++++++
 tb/tb_i2s_slave_rx.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_slave_rx.sv
// I2S slave receiver: oversamples external SCLK/LRCLK/SDATA on clk, deserialises stereo frames
// and presents {left,right} on a valid/ready port. Define I2S_RX_OVERRUN_CNT_EN for an overrun counter.
module i2s_slave_rx #(
  parameter int SAMPLE_BITS = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       i2s_sclk,
  input  logic                       i2s_lrclk,
  input  logic                       i2s_sdata,
  output logic [2*SAMPLE_BITS-1:0]   out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       overrun,
`ifdef I2S_RX_OVERRUN_CNT_EN
  input  logic                       overrun_clr,
  output logic [7:0]                 overrun_count,
`endif
  output logic                       frame_err
);

  localparam int CNT_W = $clog2(SAMPLE_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SAMPLE_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_BITS - 1);

  localparam logic [1:0] ST_HUNT  = 2'd0;
  localparam logic [1:0] ST_CAP_L = 2'd1;
  localparam logic [1:0] ST_CAP_R = 2'd2;

  logic [2:0]               sclk_sync_q, sclk_sync_d;
  logic [1:0]               lrclk_sync_q, lrclk_sync_d;
  logic [1:0]               sdata_sync_q, sdata_sync_d;
  logic                     lr_prev_q, lr_prev_d;
  logic [1:0]               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [SAMPLE_BITS-1:0]   shift_q, shift_d;
  logic [SAMPLE_BITS-1:0]   left_q, left_d;
  logic [2*SAMPLE_BITS-1:0] out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     overrun_q, overrun_d;
  logic                     frame_err_q, frame_err_d;
`ifdef I2S_RX_OVERRUN_CNT_EN
  logic [7:0]               overrun_count_q, overrun_count_d;
`endif

  logic                     sample;
  logic                     lr;
  logic                     bit_in;
  logic                     boundary;
  logic                     capture;
  logic                     word_done;
  logic                     frame_done;
  logic [SAMPLE_BITS-1:0]   shift_next;

  // Synchroniser chains; sclk carries one extra stage so a rising edge is seen as {1,0}.
  always_comb begin
    sclk_sync_d  = {sclk_sync_q[1:0], i2s_sclk};
    lrclk_sync_d = {lrclk_sync_q[0], i2s_lrclk};
    sdata_sync_d = {sdata_sync_q[0], i2s_sdata};
  end

  always_comb begin
    sample     = sclk_sync_q[1] & ~sclk_sync_q[2];
    lr         = lrclk_sync_q[1];
    bit_in     = sdata_sync_q[1];
    boundary   = sample & (lr != lr_prev_q);
    capture    = sample & ~boundary & (state_q != ST_HUNT) & (cnt_q < CNT_FULL);
    word_done  = capture & (cnt_q == CNT_LAST);
    shift_next = {shift_q[SAMPLE_BITS-2:0], bit_in};
    frame_done = enable & word_done & (state_q == ST_CAP_R);
  end

  always_comb begin
    lr_prev_d   = sample ? lr : lr_prev_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    left_d      = left_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;

    // The boundary bit itself is the I2S one-bit delay slot and is never shifted in.
    if (!enable) begin
      state_d = ST_HUNT;
      cnt_d   = '0;
    end else if (boundary) begin
      cnt_d = '0;
      case (state_q)
        ST_HUNT: begin
          if (!lr) state_d = ST_CAP_L;
        end
        ST_CAP_L: begin
          if (cnt_q == CNT_FULL) begin
            state_d = ST_CAP_R;
          end else begin
            state_d     = ST_HUNT;
            frame_err_d = 1'b1;
          end
        end
        ST_CAP_R: begin
          if (cnt_q == CNT_FULL) begin
            state_d = ST_CAP_L;
          end else begin
            state_d     = ST_HUNT;
            frame_err_d = 1'b1;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end else if (capture) begin
      shift_d = shift_next;
      cnt_d   = cnt_q + 1'b1;
      if (word_done && (state_q == ST_CAP_L)) left_d = shift_next;
    end

    // A completed frame may replace the held one only if the consumer takes it this cycle.
    if (frame_done) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = {left_q, shift_next};
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

`ifdef I2S_RX_OVERRUN_CNT_EN
  always_comb begin
    overrun_count_d = overrun_count_q;
    if (overrun_clr) begin
      overrun_count_d = {7'd0, overrun_d};
    end else if (overrun_d && (overrun_count_q != 8'hFF)) begin
      overrun_count_d = overrun_count_q + 8'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q  <= '0;
      lrclk_sync_q <= '0;
      sdata_sync_q <= '0;
      lr_prev_q    <= 1'b0;
      state_q      <= ST_HUNT;
      cnt_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef I2S_RX_OVERRUN_CNT_EN
      overrun_count_q <= '0;
`endif
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      lrclk_sync_q <= lrclk_sync_d;
      sdata_sync_q <= sdata_sync_d;
      lr_prev_q    <= lr_prev_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
`ifdef I2S_RX_OVERRUN_CNT_EN
      overrun_count_q <= overrun_count_d;
`endif
    end
  end

  // Sample datapath carries no reset; the counter and FSM decide when it is meaningful.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    left_q  <= left_d;
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
`ifdef I2S_RX_OVERRUN_CNT_EN
  assign overrun_count = overrun_count_q;
`endif

endmodule

// File: tb/tb_i2s_slave_rx.sv
// Self-checking bench for i2s_slave_rx: table-driven frames, hand-written handshake/reset/enable
// sequences and a randomized slot stream checked against a slot-level reference model.
module tb_i2s_slave_rx;
  localparam int SB = 24;

  logic          clk = 1'b0;
  logic          rst, enable, i2s_sclk, i2s_lrclk, i2s_sdata, out_ready;
  logic [2*SB-1:0] out_data;
  logic          out_valid, overrun, frame_err;
`ifdef I2S_RX_OVERRUN_CNT_EN
  logic          overrun_clr;
  logic [7:0]    overrun_count;
`endif

  always #5 clk = ~clk;

  i2s_slave_rx #(.SAMPLE_BITS(SB)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .i2s_sclk(i2s_sclk), .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun),
`ifdef I2S_RX_OVERRUN_CNT_EN
    .overrun_clr(overrun_clr), .overrun_count(overrun_count),
`endif
    .frame_err(frame_err)
  );

  int total = 0;
  int bad = 0;
  int half = 8;

  // Monitor: records every accepted frame and counts pulse cycles.
  logic [2*SB-1:0] rx_q[$];
  int rx_rd = 0;
  int err_seen = 0;
  int ovr_seen = 0;

  always @(negedge clk) begin
    if (out_valid && out_ready) rx_q.push_back(out_data);
    if (frame_err) err_seen++;
    if (overrun) ovr_seen++;
  end

  // Slot-level reference model: 0 = hunting, 1 = in left slot, 2 = in right slot.
  logic [2*SB-1:0] exp_q[$];
  int        mstate = 0;
  bit        m_seen = 0;
  bit        m_full = 0;
  logic [SB-1:0] m_left = '0;
  int        m_err = 0;
  bit        use_model = 0;

  function automatic void model_reset(bit mid_slot);
    mstate = 0;
    m_seen = mid_slot;
  endfunction

  function automatic void model_slot(bit lr, logic [SB-1:0] w, int len);
    bit full;
    full = (len >= SB + 1);
    if (!enable || !m_seen) begin
      mstate = 0;
    end else if (mstate == 0) begin
      if (!lr) mstate = 1;
    end else if (m_full) begin
      mstate = (mstate == 1) ? 2 : 1;
    end else begin
      m_err++;
      mstate = 0;
    end
    m_seen = 1;
    m_full = full;
    if (mstate == 1) m_left = w;
    if (mstate == 2 && full && use_model) exp_q.push_back({m_left, w});
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_slot(bit lr, logic [SB-1:0] w, int len, int rst_at = -1, bit ready_at_done = 0);
    model_slot(lr, w, len);
    for (int i = 0; i < len; i++) begin
      i2s_sclk  = 1'b0;
      i2s_lrclk = lr;
      i2s_sdata = (i >= 1 && i <= SB) ? w[SB-i] : 1'($urandom);
      if (i == rst_at) begin
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        model_reset(1);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_overrun", overrun, 0);
        check("rst_frame_err", frame_err, 0);
        wait_clk(half - 1);
      end else begin
        wait_clk(half);
      end
      i2s_sclk = 1'b1;
      if (ready_at_done && i == SB) begin
        // Frame completion lands 3 clk after the rise of the last right bit.
        wait_clk(2);
        out_ready = 1'b1;
        wait_clk(1);
        out_ready = 1'b0;
        wait_clk(half - 3);
      end else begin
        wait_clk(half);
      end
    end
  endtask

  task automatic send_frame(logic [SB-1:0] l, logic [SB-1:0] r, int llen = 32, int rlen = 32);
    send_slot(1'b0, l, llen);
    send_slot(1'b1, r, rlen);
  endtask

  task automatic check_model(string name);
    while (rx_rd < rx_q.size()) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s_extra: got frame %h, none expected", name, rx_q[rx_rd]);
      end else begin
        check(name, rx_q[rx_rd], exp_q.pop_front());
      end
      rx_rd++;
    end
    check({name, "_missing"}, exp_q.size(), 0);
  endtask

  task automatic expect_rx(string name, logic [2*SB-1:0] val);
    if (rx_rd < rx_q.size()) begin
      check(name, rx_q[rx_rd], val);
      rx_rd++;
    end else begin
      total++;
      bad++;
      $display("FAIL %s: got no frame expected %h", name, val);
    end
  endtask

  typedef struct {
    logic [SB-1:0] l;
    logic [SB-1:0] r;
    int llen;
    int rlen;
    int exp_frames;
    int exp_err;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #900us;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0, f0, o0, me0;

    tbl[0] = '{24'h111111, 24'h222222, 32, 32, 1, 0};
    tbl[1] = '{24'hA5A5A5, 24'h5A5A5A, 25, 25, 1, 0};
    tbl[2] = '{24'hFFFFFF, 24'h000001, 40, 26, 1, 0};
    tbl[3] = '{24'h123456, 24'h654321, 10, 32, 0, 1};
    tbl[4] = '{24'h0F0F0F, 24'hF0F0F0, 32, 32, 1, 0};
    tbl[5] = '{24'h800000, 24'h000080, 32, 20, 0, 0};
    tbl[6] = '{24'h7FFFFF, 24'hC00003, 32, 32, 0, 1};
    tbl[7] = '{24'h13579B, 24'h2468AC, 32, 24, 0, 0};
    tbl[8] = '{24'hDEADBE, 24'hEFCAFE, 32, 32, 0, 1};
    tbl[9] = '{24'h000000, 24'hFFFFFF, 32, 32, 1, 0};

    rst = 1'b1;
    enable = 1'b1;
    i2s_sclk = 1'b0;
    i2s_lrclk = 1'b1;
    i2s_sdata = 1'b0;
    out_ready = 1'b1;
`ifdef I2S_RX_OVERRUN_CNT_EN
    overrun_clr = 1'b0;
`endif
    wait_clk(3);
    check("reset_valid", out_valid, 0);
    check("reset_data", out_data, 0);
    check("reset_overrun", overrun, 0);
    check("reset_frame_err", frame_err, 0);
`ifdef I2S_RX_OVERRUN_CNT_EN
    check("reset_ovr_count", overrun_count, 0);
`endif
    rst = 1'b0;
    model_reset(0);
    wait_clk(2);

    // Basic frames: the first frame after reset only aligns the receiver.
    use_model = 1;
    e0 = err_seen;
    f0 = rx_q.size();
    repeat (3) send_frame(24'hABCDEF, 24'h123456);
    check("basic_count", rx_q.size() - f0, 2);
    check("basic_data", rx_q[rx_q.size()-1], 48'hABCDEF123456);
    check("basic_err", err_seen - e0, 0);
    check_model("basic_model");

    for (int i = 0; i < 10; i++) begin
      e0 = err_seen;
      f0 = rx_q.size();
      send_frame(tbl[i].l, tbl[i].r, tbl[i].llen, tbl[i].rlen);
      check($sformatf("tbl%0d_frames", i), rx_q.size() - f0, tbl[i].exp_frames);
      check($sformatf("tbl%0d_err", i), err_seen - e0, tbl[i].exp_err);
      if (tbl[i].exp_frames != 0)
        check($sformatf("tbl%0d_data", i), rx_q[rx_q.size()-1], {tbl[i].l, tbl[i].r});
    end
    check_model("tbl_model");

    // Overrun: B is dropped while A is held.
    use_model = 0;
    out_ready = 1'b0;
    o0 = ovr_seen;
    e0 = err_seen;
    send_frame(24'h111111, 24'h222222);
    send_frame(24'h333333, 24'h444444);
    check("ovr_pulses", ovr_seen - o0, 1);
    check("ovr_valid", out_valid, 1);
    check("ovr_data", out_data, 48'h111111222222);
    check("ovr_err", err_seen - e0, 0);
`ifdef I2S_RX_OVERRUN_CNT_EN
    check("ovr_count", overrun_count, 1);
`endif
    out_ready = 1'b1;
    wait_clk(1);
    out_ready = 1'b0;
    wait_clk(2);
    check("ovr_valid_cleared", out_valid, 0);
    expect_rx("ovr_rx", 48'h111111222222);
    check("ovr_no_extra", rx_q.size() - rx_rd, 0);

    // Accept in the very cycle a new frame completes.
    o0 = ovr_seen;
    send_frame(24'h55AA55, 24'hAA55AA);
    send_slot(1'b0, 24'hC0FFEE, 32);
    send_slot(1'b1, 24'h0BADF0, 32, -1, 1);
    check("simul_valid", out_valid, 1);
    check("simul_data", out_data, 48'hC0FFEE0BADF0);
    check("simul_overrun", ovr_seen - o0, 0);
    expect_rx("simul_old", 48'h55AA55AA55AA);
    out_ready = 1'b1;
    wait_clk(2);
    expect_rx("simul_new", 48'hC0FFEE0BADF0);
    check("simul_drained", out_valid, 0);

    // Reset mid-left-slot with a frame pending.
    out_ready = 1'b0;
    e0 = err_seen;
    send_frame(24'h0A0B0C, 24'h0D0E0F);
    send_slot(1'b0, 24'h777777, 32, 12);
    send_slot(1'b1, 24'h888888, 32);
    out_ready = 1'b1;
    send_frame(24'h9ABCDE, 24'hF01234);
    expect_rx("rstl_first", 48'h9ABCDEF01234);
    check("rstl_no_extra", rx_q.size() - rx_rd, 0);

    // Reset released in the middle of a right slot.
    send_slot(1'b0, 24'h121212, 32);
    send_slot(1'b1, 24'h343434, 32, 9);
    send_frame(24'h565656, 24'h787878);
    expect_rx("rstr_first", 48'h565656787878);
    check("rstr_no_extra", rx_q.size() - rx_rd, 0);
    check("rst_err", err_seen - e0, 0);

    // Enable low for three frames, with a frame held and short slots in the gap.
    out_ready = 1'b0;
    e0 = err_seen;
    send_frame(24'h246802, 24'h135791);
    enable = 1'b0;
    send_frame(24'h111000, 24'h000111);
    send_frame(24'h222000, 24'h000222, 10, 32);
    send_frame(24'h333000, 24'h000333, 32, 12);
    check("en_hold_valid", out_valid, 1);
    check("en_hold_data", out_data, 48'h246802135791);
    out_ready = 1'b1;
    wait_clk(2);
    expect_rx("en_held", 48'h246802135791);
    check("en_no_frames", rx_q.size() - rx_rd, 0);
    enable = 1'b1;
    send_frame(24'hCAFE01, 24'hBEEF02);
    send_frame(24'h0F1E2D, 24'h3C4B5A);
    expect_rx("en_first", 48'hCAFE01BEEF02);
    expect_rx("en_second", 48'h0F1E2D3C4B5A);
    check("en_err", err_seen - e0, 0);

    // Randomized slot stream at the fastest legal sclk.
    use_model = 1;
    half = 4;
    out_ready = 1'b1;
    e0 = err_seen;
    me0 = m_err;
    for (int s = 0; s < 48; s++) begin
      int len;
      if ($urandom_range(0, 9) == 0) len = $urandom_range(1, SB);
      else len = $urandom_range(SB + 1, 36);
      enable = ($urandom_range(0, 15) != 0);
      send_slot(1'(s % 2), SB'($urandom), len);
    end
    enable = 1'b1;
    wait_clk(8);
    check_model("rand_model");
    check("rand_err", err_seen - e0, m_err - me0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
